gate_sweep_controller: RTL
==========================

// Module: gate_sweep_controller
// PURPOSE
//  Sequencer that exhaustively exercises a 2-input combinational gate block (A, B -> Y).
//  Drives all four input vectors in fixed order {A,B} = 11, 00, 10, 01.
//  Samples Y for each vector and checks it against an expected truth table.
//  Sits between a host/start source and the gate under test; reports pass/fail per run.
// PARAMETERS
//  SETTLE_CYCLES  2        cycles each vector is held before Y is sampled (legal >= 1)
//  EXPECTED       4'b1000  expected Y, indexed by {A,B} (default = AND)
// PORTS
//  clk       in   1  clock, all state updates on rising edge
//  reset     in   1  synchronous, active-high reset
//  start     in   1  begin a sweep; honoured only in IDLE
//  abort     in   1  cancel a sweep in progress
//  y_in      in   1  Y output of the gate under test
//  a_out     out  1  A input to the gate under test (registered)
//  b_out     out  1  B input to the gate under test (registered)
//  busy      out  1  high while in APPLY
//  done      out  1  one-cycle pulse when a sweep completes (not asserted on abort)
//  pass      out  1  high from the done cycle if mismatch == 0; held until next start/abort/reset
//  mismatch  out  4  bit {A,B} set if sampled Y != EXPECTED[{A,B}]
//  y_log     out  4  sampled Y values, indexed by {A,B}
//  err_cnt   out  3  number of mismatching vectors in the current run (0..4)
//  vec_idx   out  2  sequence position of the vector being driven (0..3)
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, all outputs 0, settle counter 0. Reset overrides start/abort.
//  - FSM states: IDLE, APPLY, DONE.
//  - IDLE:
//    - a_out = b_out = 0.
//    - start=1 and abort=0 -> APPLY next cycle with vec_idx=0.
//    - On the same edge: clear mismatch, y_log, err_cnt and pass.
//    - start=1 together with abort=1 -> stay in IDLE, results untouched.
//  - APPLY:
//    - Vector map: vec_idx 0->{1,1}, 1->{0,0}, 2->{1,0}, 3->{0,1}.
//    - a_out/b_out hold the vector for exactly SETTLE_CYCLES cycles.
//    - Sampling: on the edge ending the last of those cycles, y_in is captured into y_log[{A,B}].
//    - On that same edge: if y_in != EXPECTED[{A,B}], set mismatch[{A,B}] and increment err_cnt.
//    - Then advance vec_idx; after vec_idx 3, go to DONE.
//  - DONE:
//    - Lasts exactly 1 cycle: done=1, busy=0, a_out=b_out=0.
//    - pass = (mismatch == 0) becomes valid this cycle.
//    - Next state IDLE; start during DONE is ignored.
//  - Latency: start sampled at edge t -> first vector driven from t+1 -> done high in cycle t+1+4*SETTLE_CYCLES.
//    - SETTLE_CYCLES=2: done at t+9.
//  - Back-to-back: start held high restarts in the cycle after DONE (IDLE lasts 1 cycle).
//  - abort=1 in APPLY:
//    - Next state IDLE; a_out/b_out = 0 next cycle; done not pulsed; pass stays 0.
//    - Partial y_log/mismatch/err_cnt are kept for debug.
//  - abort in IDLE or DONE: no effect. start while busy: ignored.
//  - Reset mid-sweep: next cycle IDLE, all outputs 0.
//  - vec_idx wraps 3 -> 0 only via a new start. err_cnt cannot exceed 4 (3 bits, no overflow).
//  - y_in is treated as combinational from a_out/b_out; no synchronizer.
// TESTING
//  1. Correct AND model, defaults, start pulse at t -> a/b = 11,00,10,01 for 2 cycles each;
//     done at t+9; y_log=1000, mismatch=0, err_cnt=0, pass=1.
//  2. Y stuck-at-0 vs EXPECTED=1000 -> mismatch=1000, err_cnt=1, pass=0, done still pulses at t+9.
//  3. XOR model with EXPECTED=4'b0110, SETTLE_CYCLES=1 -> done at t+5, y_log=0110, pass=1.
//  4. abort asserted in cycle t+4 (vector 1 active) -> IDLE at t+5, a/b=00, no done, pass=0,
//     y_log bit {1,1} captured.
//  5. reset at t+3 mid-sweep -> all outputs 0 from t+4; a later start runs a full clean sweep.
//  6. start held high continuously -> done pulses every 10 cycles (1 IDLE + 8 APPLY + 1 DONE);
//     start+abort together in IDLE -> stays IDLE, no busy.

Source files
------------

// File: rtl/gate_sweep_controller.sv
// -----------------------------------------------------------------------------
// gate_sweep_controller
//
// Purpose:
//   Exhaustively exercises a 2-input combinational gate (A, B -> Y). On start it
//   drives the vectors {A,B} = 11, 00, 10, 01 in that order, holding each for
//   SETTLE_CYCLES cycles, samples Y at the end of each hold and compares it to
//   the EXPECTED truth table. A one-cycle done pulse closes a completed sweep,
//   and pass reports whether every vector matched.
//
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before Y is sampled (>= 1)
//   EXPECTED      - expected Y, indexed by {A,B} (default 4'b1000 = AND)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   begin a sweep (honoured only when idle and abort is low)
//   abort     in   cancel a sweep in progress
//   y_in      in   Y output of the gate under test
//   a_out     out  A input to the gate under test (registered)
//   b_out     out  B input to the gate under test (registered)
//   busy      out  high while vectors are being applied
//   done      out  one-cycle pulse when a sweep completes (not on abort)
//   pass      out  high from the done cycle when no vector mismatched
//   mismatch  out  bit {A,B} set when sampled Y differed from EXPECTED
//   y_log     out  sampled Y values, indexed by {A,B}
//   err_cnt   out  number of mismatching vectors in the current run (0..4)
//   vec_idx   out  sequence position of the vector being driven (0..3)
// -----------------------------------------------------------------------------
module gate_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch,
  output logic [3:0] y_log,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
);

  // A one-cycle hold still needs a 1-bit counter so the compare below is legal.
  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       vec_idx_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       mismatch_q;
  logic [3:0]       y_log_q;
  logic [2:0]       err_cnt_q;

  // Sample-edge results, computed from the vector currently on the pins.
  logic [1:0]       sel;
  logic             last_hold;
  logic             miss;
  logic [3:0]       y_log_d;
  logic [3:0]       mismatch_d;
  logic [2:0]       err_cnt_d;
  logic [1:0]       next_ab_d;

  // Sequence position -> {A,B}.
  function automatic logic [1:0] vec_map(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_map = 2'b11;
      2'd1:    vec_map = 2'b00;
      2'd2:    vec_map = 2'b10;
      default: vec_map = 2'b01;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any conditional update so no latch is inferred.
    sel        = {a_q, b_q};
    last_hold  = (cnt_q == LAST_CNT);
    miss       = y_in ^ EXPECTED[sel];
    y_log_d    = y_log_q;
    mismatch_d = mismatch_q;
    y_log_d[sel] = y_in;
    if (miss) begin
      mismatch_d[sel] = 1'b1;
    end
    // At most one increment per vector, so four vectors never overflow 3 bits.
    err_cnt_d  = err_cnt_q + {2'b00, miss};
    next_ab_d  = vec_map(vec_idx_q + 2'd1);
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vec_idx_q  <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 4'd0;
      y_log_q    <= 4'd0;
      err_cnt_q  <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // start together with abort is treated as no request.
          if (start && !abort) begin
            state_q    <= ST_APPLY;
            cnt_q      <= '0;
            vec_idx_q  <= 2'd0;
            {a_q, b_q} <= vec_map(2'd0);
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            mismatch_q <= 4'd0;
            y_log_q    <= 4'd0;
            err_cnt_q  <= 3'd0;
          end
        end

        ST_APPLY: begin
          if (abort) begin
            // Partial results stay visible for debug; the vector under test is
            // not sampled even if this is its last hold cycle.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b0;
          end else if (last_hold) begin
            cnt_q      <= '0;
            y_log_q    <= y_log_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
            if (vec_idx_q == 2'd3) begin
              state_q    <= ST_DONE;
              {a_q, b_q} <= 2'b00;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              // Use the updated map so the last vector counts toward pass.
              pass_q     <= (mismatch_d == 4'd0);
            end else begin
              vec_idx_q  <= vec_idx_q + 2'd1;
              {a_q, b_q} <= next_ab_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // Always one cycle; start here is only acted on from the following IDLE.
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;
  assign y_log    = y_log_q;
  assign err_cnt  = err_cnt_q;
  assign vec_idx  = vec_idx_q;

endmodule
